// File: rtl/peripheral_noc_pkg.sv
// -----------------------------------------------------------------------------
// peripheral_noc_pkg
//   Shared NoC types for the peripheral/tile side of the mesh.
//   - NOC_FLIT_WIDTH : default flit payload width used across the NoC
//   - noc_flit_t     : one flit payload
//   - noc_entry_t    : one stored flit plus its end-of-packet marker
//   - counter_width  : width of a counter that must hold 0..depth inclusive
// -----------------------------------------------------------------------------
package peripheral_noc_pkg;

   localparam int NOC_FLIT_WIDTH = 32;

   typedef logic [NOC_FLIT_WIDTH-1:0] noc_flit_t;

   typedef struct packed {
      noc_flit_t flit;
      logic      last;
   } noc_entry_t;

   // A counter of stored items must represent DEPTH itself, not just DEPTH-1.
   function automatic int counter_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/soc_noc_packet_buffer_fifo_core.sv
// -----------------------------------------------------------------------------
// soc_noc_fifo_core
//   Flit storage for the packet buffer: memory, read/write pointers, fill level
//   and the write-side ready. The caller qualifies push/pop with ready/valid,
//   so push is only raised while push_ready=1 and pop only while fill_level!=0.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   push, push_flit,
//   push_last, push_ready   write side; push_ready depends on registered state only
//   pop, pop_flit, pop_last read side; pop_* is the head entry, read combinationally
//   fill_level              number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module soc_noc_fifo_core
   import peripheral_noc_pkg::*;
#(
   parameter  int FLIT_WIDTH = NOC_FLIT_WIDTH,
   parameter  int DEPTH      = 16,
   localparam int CW         = counter_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [FLIT_WIDTH-1:0] push_flit,
   input  logic                  push_last,
   output logic                  push_ready,
   input  logic                  pop,
   output logic [FLIT_WIDTH-1:0] pop_flit,
   output logic                  pop_last,
   output logic [CW-1:0]         fill_level
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [FLIT_WIDTH-1:0] flit;
      logic                  last;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            rst_done;

   // NOTE: storage has no reset; contents are only observable after a push
   // has written them, and leaving it out keeps the array mappable to RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{flit: push_flit, last: push_last};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         rst_done   <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         // DEPTH is a power of two, so natural pointer overflow is the wrap.
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fill_level <= fill_level + CW'(1);
            2'b01:   fill_level <= fill_level - CW'(1);
            default: fill_level <= fill_level;
         endcase
      end
   end

   // Held low through reset and until the first edge after release. Being
   // registered-only, a pop in the same cycle never frees a slot early.
   assign push_ready = rst_done && (fill_level != CW'(DEPTH));

   assign pop_flit = mem[rd_ptr].flit;
   assign pop_last = mem[rd_ptr].last;

endmodule

// File: rtl/soc_noc_packet_buffer.sv
// -----------------------------------------------------------------------------
// soc_noc_packet_buffer
//   Injection buffer between a tile's NoC adapter and the mesh router input.
//   With FULLPACKET=1 a packet is offered to the router only once its last
//   flit is stored; if one oversize packet fills the FIFO, the buffer falls
//   back to cut-through for that packet (fwd_lock) so it cannot deadlock.
//   With FULLPACKET=0 it is a plain FIFO.
// Ports
//   clk, rst_n                           clock, asynchronous active-low reset
//   in_flit, in_last, in_valid, in_ready tile side (ready/valid)
//   out_flit, out_last, out_valid,
//   out_ready                            router side (ready/valid)
//   fill_level                           stored flits
//   packet_count                         stored complete packets
// -----------------------------------------------------------------------------
module soc_noc_packet_buffer
   import peripheral_noc_pkg::*;
#(
   parameter  int FLIT_WIDTH = NOC_FLIT_WIDTH,
   parameter  int DEPTH      = 16,
   parameter  int FULLPACKET = 1,
   localparam int CW         = counter_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FLIT_WIDTH-1:0] in_flit,
   input  logic                  in_last,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [FLIT_WIDTH-1:0] out_flit,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CW-1:0]         fill_level,
   output logic [CW-1:0]         packet_count
);

   logic push;
   logic pop;
   logic push_eop;
   logic pop_eop;
   logic fwd_lock;

   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;
   assign push_eop = push && in_last;
   assign pop_eop  = pop && out_last;

   soc_noc_fifo_core #(
      .FLIT_WIDTH (FLIT_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_flit  (in_flit),
      .push_last  (in_last),
      .push_ready (in_ready),
      .pop        (pop),
      .pop_flit   (out_flit),
      .pop_last   (out_last),
      .fill_level (fill_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         packet_count <= '0;
      end else begin
         case ({push_eop, pop_eop})
            2'b10:   packet_count <= packet_count + CW'(1);
            2'b01:   packet_count <= packet_count - CW'(1);
            default: packet_count <= packet_count;
         endcase
      end
   end

   // A full FIFO holding no complete packet can only be one packet larger
   // than the buffer; let it stream until its last flit has left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_lock <= 1'b0;
      end else if (pop_eop) begin
         fwd_lock <= 1'b0;
      end else if ((fill_level == CW'(DEPTH)) && (packet_count == '0)) begin
         fwd_lock <= 1'b1;
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      out_valid = 1'b0;
      if (fill_level != '0) begin
         if (FULLPACKET == 0) begin
            out_valid = 1'b1;
         end else begin
            out_valid = (packet_count != '0) || fwd_lock;
         end
      end
   end

endmodule

// File: tb/tb_soc_noc_packet_buffer.sv
// -----------------------------------------------------------------------------
// tb_soc_noc_packet_buffer
//   Two buffers share clk/rst_n: dut (FULLPACKET=1) and dut_ff (FULLPACKET=0).
//   Directed vector table for single-packet and packet-count corner cases,
//   then hand-written sequences for full FIFO, cut-through fallback,
//   random traffic against a scoreboard, and mid-packet reset.
// -----------------------------------------------------------------------------
module tb_soc_noc_packet_buffer;
   import peripheral_noc_pkg::*;

   localparam int FW    = NOC_FLIT_WIDTH;
   localparam int DEPTH = 16;
   localparam int CW    = counter_width(DEPTH);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // FULLPACKET=1 instance
   logic [FW-1:0] in_flit;
   logic          in_last, in_valid, in_ready;
   logic [FW-1:0] out_flit;
   logic          out_last, out_valid, out_ready;
   logic [CW-1:0] fill_level, packet_count;

   // FULLPACKET=0 instance
   logic [FW-1:0] p_in_flit;
   logic          p_in_last, p_in_valid, p_in_ready;
   logic [FW-1:0] p_out_flit;
   logic          p_out_last, p_out_valid, p_out_ready;
   logic [CW-1:0] p_fill_level, p_packet_count;

   soc_noc_packet_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH), .FULLPACKET(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
      .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .fill_level(fill_level), .packet_count(packet_count)
   );

   soc_noc_packet_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH), .FULLPACKET(0)) dut_ff (
      .clk(clk), .rst_n(rst_n),
      .in_flit(p_in_flit), .in_last(p_in_last), .in_valid(p_in_valid), .in_ready(p_in_ready),
      .out_flit(p_out_flit), .out_last(p_out_last), .out_valid(p_out_valid), .out_ready(p_out_ready),
      .fill_level(p_fill_level), .packet_count(p_packet_count)
   );

   int total  = 0;
   int passed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   typedef struct {
      string     tag;
      logic      iv;
      noc_flit_t fl;
      logic      il;
      logic      ordy;
      logic      e_ir;
      logic      e_ov;
      noc_flit_t e_flit;
      logic      e_last;
      int        e_fill;
      int        e_pkt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input string tag, input logic iv, input noc_flit_t fl,
                               input logic il, input logic ordy, input logic e_ir,
                               input logic e_ov, input noc_flit_t e_flit, input logic e_last,
                               input int e_fill, input int e_pkt);
      vec_t v;
      v.tag = tag; v.iv = iv; v.fl = fl; v.il = il; v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_flit = e_flit; v.e_last = e_last;
      v.e_fill = e_fill; v.e_pkt = e_pkt;
      vecs.push_back(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Watchdog: every sequence below is also bounded on its own.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Inputs driven one time unit after posedge, outputs sampled at negedge.
      //       tag   iv  in_flit    il ordy ir ov exp_flit   el fill pkt
      // T1: 3-flit packet held back until its last flit is stored
      add("t1", 1, 32'h0000_00A0, 0, 1, 1, 0, 32'h0,         0, 0, 0);
      add("t1", 1, 32'h0000_00A1, 0, 1, 1, 0, 32'h0,         0, 1, 0);
      add("t1", 1, 32'h0000_00A2, 1, 1, 1, 0, 32'h0,         0, 2, 0);
      add("t1", 0, 32'h0,         0, 1, 1, 1, 32'h0000_00A0, 0, 3, 1);
      add("t1", 0, 32'h0,         0, 1, 1, 1, 32'h0000_00A1, 0, 2, 1);
      add("t1", 0, 32'h0,         0, 1, 1, 1, 32'h0000_00A2, 1, 1, 1);
      add("t1", 0, 32'h0,         0, 1, 1, 0, 32'h0,         0, 0, 0);
      // T4: push-last and pop-last in the same cycle keep packet_count at 2
      add("t4", 1, 32'h0000_00B0, 1, 0, 1, 0, 32'h0,         0, 0, 0);
      add("t4", 1, 32'h0000_00C0, 1, 0, 1, 1, 32'h0000_00B0, 1, 1, 1);
      add("t4", 1, 32'h0000_00D0, 1, 1, 1, 1, 32'h0000_00B0, 1, 2, 2);
      add("t4", 1, 32'h0000_00E0, 1, 1, 1, 1, 32'h0000_00C0, 1, 2, 2);
      add("t4", 0, 32'h0,         0, 1, 1, 1, 32'h0000_00D0, 1, 2, 2);
      add("t4", 0, 32'h0,         0, 1, 1, 1, 32'h0000_00E0, 1, 1, 1);
      add("t4", 0, 32'h0,         0, 0, 1, 0, 32'h0,         0, 0, 0);

      in_flit = '0; in_last = 0; in_valid = 0; out_ready = 0;
      p_in_flit = '0; p_in_last = 0; p_in_valid = 0; p_out_ready = 0;

      // ---------------- reset state ----------------
      #12;
      check("rst in_ready",     in_ready,     0);
      check("rst out_valid",    out_valid,    0);
      check("rst fill_level",   fill_level,   0);
      check("rst packet_count", packet_count, 0);
      check("rst ff in_ready",  p_in_ready,   0);
      check("rst ff out_valid", p_out_valid,  0);
      #10 rst_n = 1'b1;
      #1;
      check("post-release in_ready before edge", in_ready, 0);
      tick();
      check("in_ready after first edge", in_ready, 1);

      // ---------------- table: T1 and T4 ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         in_valid  = vecs[i].iv;
         in_flit   = vecs[i].fl;
         in_last   = vecs[i].il;
         out_ready = vecs[i].ordy;
         @(negedge clk);
         check($sformatf("%s[%0d] in_ready", vecs[i].tag, i), in_ready, vecs[i].e_ir);
         check($sformatf("%s[%0d] out_valid", vecs[i].tag, i), out_valid, vecs[i].e_ov);
         check($sformatf("%s[%0d] fill_level", vecs[i].tag, i), fill_level, vecs[i].e_fill);
         check($sformatf("%s[%0d] packet_count", vecs[i].tag, i), packet_count, vecs[i].e_pkt);
         if (vecs[i].e_ov) begin
            check($sformatf("%s[%0d] out_flit", vecs[i].tag, i), out_flit, vecs[i].e_flit);
            check($sformatf("%s[%0d] out_last", vecs[i].tag, i), out_last, vecs[i].e_last);
         end
         tick();
      end
      in_valid = 0; in_last = 0; out_ready = 0;

      // ---------------- T2: plain FIFO full, no bypass ----------------
      for (int i = 0; i < DEPTH; i++) begin
         p_in_valid = 1; p_in_flit = 32'h200 + i; p_in_last = 0; p_out_ready = 0;
         tick();
      end
      @(negedge clk);
      check("t2 full fill_level", p_fill_level, DEPTH);
      check("t2 full in_ready",   p_in_ready,   0);
      check("t2 full out_valid",  p_out_valid,  1);
      check("t2 head flit",       p_out_flit,   32'h200);
      tick();
      p_in_valid = 1; p_in_flit = 32'h2FF; p_out_ready = 1;
      @(negedge clk);
      check("t2 no bypass in_ready", p_in_ready, 0);
      tick();
      p_in_valid = 0;
      @(negedge clk);
      check("t2 fill after one pop", p_fill_level, DEPTH - 1);
      for (int j = 1; j < DEPTH; j++) begin
         if (j > 1) @(negedge clk);
         check($sformatf("t2 drain flit %0d", j), p_out_flit, 32'h200 + j);
         tick();
      end
      @(negedge clk);
      check("t2 empty fill_level", p_fill_level, 0);
      check("t2 empty out_valid",  p_out_valid,  0);
      tick();
      p_out_ready = 0;

      // ---------------- T3: oversize packet, cut-through fallback ----------------
      begin
         int  pi, oi;
         bit  seen_full, seen_lock, early;
         pi = 0; oi = 0; seen_full = 0; seen_lock = 0; early = 0;
         out_ready = 1;
         for (int cyc = 0; cyc < 200 && oi < 20; cyc++) begin
            in_valid = (pi < 20);
            in_flit  = 32'h300 + pi;
            in_last  = (pi == 19);
            @(negedge clk);
            if (out_valid && !seen_full) early = 1;
            if (fill_level == CW'(DEPTH)) seen_full = 1;
            if (dut.fwd_lock) seen_lock = 1;
            if (out_valid && out_ready) begin
               check($sformatf("t3 flit %0d", oi), out_flit, 32'h300 + oi);
               check($sformatf("t3 last %0d", oi), out_last, (oi == 19));
               oi++;
            end
            if (in_valid && in_ready) pi++;
            tick();
         end
         in_valid = 0; in_last = 0;
         check("t3 all flits out", oi, 20);
         check("t3 reached full", seen_full, 1);
         check("t3 fwd_lock set", seen_lock, 1);
         check("t3 no output before full", early, 0);
         @(negedge clk);
         check("t3 fwd_lock cleared", dut.fwd_lock, 0);
         check("t3 fill_level", fill_level, 0);
         check("t3 packet_count", packet_count, 0);
         tick();
         out_ready = 0;
      end

      // ---------------- T5: random traffic vs scoreboard ----------------
      begin
         noc_entry_t sb[$];
         noc_entry_t exp_e;
         int        n_flits, pushed, remaining, cyc;
         bit        pending, prev_stall, prev_last;
         noc_flit_t prev_flit;
         n_flits = 3000; pushed = 0; remaining = 0; cyc = 0;
         pending = 0; prev_stall = 0; prev_last = 0; prev_flit = '0;
         while ((pushed < n_flits || sb.size() != 0) && cyc < 60000) begin
            if (!pending && pushed < n_flits) begin
               if (remaining == 0) remaining = $urandom_range(1, 8);
               in_flit = $urandom;
               in_last = (remaining == 1) || (pushed == n_flits - 1);
               pending = 1;
            end
            in_valid  = pending && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (prev_stall) begin
               check("t5 stalled flit stable", out_flit, prev_flit);
               check("t5 stalled last stable", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check("t5 pop with empty scoreboard", 1, 0);
               end else begin
                  exp_e = sb.pop_front();
                  check("t5 flit", out_flit, exp_e.flit);
                  check("t5 last", out_last, exp_e.last);
               end
            end
            if (in_valid && in_ready) begin
               sb.push_back('{flit: in_flit, last: in_last});
               pushed++;
               if (remaining > 0) remaining--;
               if (in_last) remaining = 0;
               pending = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_flit  = out_flit;
            prev_last  = out_last;
            tick();
            cyc++;
         end
         in_valid = 0; in_last = 0; out_ready = 0;
         check("t5 completed in budget", (pushed == n_flits) && (sb.size() == 0), 1);
      end

      // ---------------- T6: reset mid-packet ----------------
      out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1; in_flit = 32'h600 + i; in_last = (i == 1);
         tick();
      end
      in_valid = 0; in_last = 0;
      @(negedge clk);
      check("t6 pre fill_level",   fill_level,   5);
      check("t6 pre packet_count", packet_count, 1);
      check("t6 pre out_valid",    out_valid,    1);
      #2 rst_n = 1'b0;
      #1;
      check("t6 async out_valid",    out_valid,    0);
      check("t6 async in_ready",     in_ready,     0);
      check("t6 async fill_level",   fill_level,   0);
      check("t6 async packet_count", packet_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      begin
         int got;
         got = 0;
         out_ready = 1;
         for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
            in_valid = (cyc < 2);
            in_flit  = 32'h700 + cyc;
            in_last  = (cyc == 1);
            @(negedge clk);
            if (cyc < 2) check($sformatf("t6 in_ready %0d", cyc), in_ready, 1);
            if (out_valid && out_ready) begin
               check($sformatf("t6 flit %0d", got), out_flit, 32'h700 + got);
               check($sformatf("t6 last %0d", got), out_last, (got == 1));
               got++;
            end
            tick();
         end
         in_valid = 0; in_last = 0;
         check("t6 packet delivered", got, 2);
         @(negedge clk);
         check("t6 final fill_level", fill_level, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
